exp_sum_buffer: RTL and testbench
=================================

# exp_sum_buffer

Softmax stage directly downstream of the exponent block. Captures one frame of `number_of_data` exponent results into a local buffer while accumulating their sum. Then replays each stored exponent, paired with the final frame sum, to the divider stage over a valid/ready handshake. Single-frame operation: once the frame is fully drained the block holds its done flag until reset.

## Interface
- `data_size`, 32, width of each exponent value and of the emitted sum (unsigned fixed point, same format as the exponent block output).
- `number_of_data`, 10, frame length; legal range 1..255.

- `clock_i`  input  1  single clock, rising edge.
- `reset_n_i`  input  1  reset; asynchronous, active-low.
- `exp_i`  input  data_size  exponent value from the exponent block.
- `exp_valid_i`  input  1  `exp_i` valid this cycle (single-cycle pulses, no backpressure).
- `exp_done_i`  input  1  exponent block has finished the frame (level).
- `div_ready_i`  input  1  divider accepts the current pair.
- `div_valid_o`  output  1  `div_exp_o`/`div_sum_o`/`div_index_o` valid.
- `div_exp_o`  output  data_size  stored exponent being replayed.
- `div_sum_o`  output  data_size  frame sum.
- `div_index_o`  output  8  buffer index of `div_exp_o`.
- `sum_valid_o`  output  1  frame sum final; stays high until reset.
- `sum_done_o`  output  1  all entries accepted by divider; sticky until reset.

## Operation
- Storage: `number_of_data` x `data_size` buffer; 8-bit write counter `wr_cnt`; 8-bit read counter `rd_cnt`; accumulator `acc` of `data_size`+8 bits.
- FSM states:
  - COLLECT (reset state):
    - Each cycle with `exp_valid_i` and `wr_cnt` < `number_of_data`: write `buffer[wr_cnt]` and set `acc += exp_i`, `wr_cnt += 1`.
    - Valid pulses arriving when `wr_cnt` == `number_of_data` are dropped.
  - COLLECT -> SUM: when `wr_cnt` reaches `number_of_data`, or when `exp_done_i` is high with `wr_cnt` > 0. On a short frame only `wr_cnt` entries are replayed.
    - If `exp_valid_i` and `exp_done_i` arrive in the same cycle, the sample is captured and counted first.
    - `exp_done_i` with `wr_cnt` == 0 is ignored.
  - SUM: one cycle. Registers `div_sum_o` from `acc` (see Configuration) and sets `sum_valid_o`. Goes to STREAM.
  - STREAM:
    - `div_valid_o` = 1, `div_exp_o` = `buffer[rd_cnt]`, `div_index_o` = `rd_cnt`.
    - On `div_valid_o` && `div_ready_i`, `rd_cnt += 1` and the outputs advance on the next edge.
    - Acceptance of index `wr_cnt`-1 -> DONE.
  - DONE: `div_valid_o` = 0; `sum_done_o` = 1; all inputs ignored.
- `div_exp_o`/`div_index_o` hold their value while `div_valid_o` && !`div_ready_i`. No change is allowed while stalled.
- Reset mid-operation (any state): FSM returns to COLLECT, counters and `acc` clear, and all outputs go to their reset values immediately. Buffer contents are don't-care.

## Timing
- Reset values: `div_valid_o`=0, `div_exp_o`=0, `div_sum_o`=0, `div_index_o`=0, `sum_valid_o`=0, `sum_done_o`=0.
- All outputs are registered.
- Edge k captures the last sample:
  - Edge k+1: state becomes SUM.
  - Edge k+2: `sum_valid_o`=1, `div_valid_o`=1, `div_index_o`=0.
- Throughput with `div_ready_i` held high: one pair per cycle. `sum_done_o` rises on the edge after the last acceptance.
- Accumulation: zero-latency per sample; back-to-back `exp_valid_i` every cycle is supported.

## Configuration
- `EXP_SUM_SATURATE_EN` defined: if `acc` exceeds 2^`data_size`-1, `div_sum_o` = all ones.
- Not defined: `div_sum_o` = `acc[data_size-1:0]` (modulo wrap).
- The accumulator width is the same in both builds.

## Test plan
- Full frame, N=10, each `exp_i`=0x0001_0000, `div_ready_i`=1 -> `div_sum_o`=0x000A_0000 two cycles after the 10th sample; indices 0..9 on consecutive cycles; `sum_done_o` high next edge.
- Backpressure: toggle `div_ready_i` 1,0,0,1 during STREAM with `exp_i`=index+1 -> each of `div_exp_o` 1..10 presented exactly once, held stable during stalls.
- Short frame: 4 samples (5,6,7,8) then `exp_done_i` -> `div_sum_o`=26; indices 0..3 only; `sum_done_o` after the 4th acceptance.
- Overflow: N=2, `exp_i`=0xFFFF_FFFF twice -> `div_sum_o`=0xFFFF_FFFF with `EXP_SUM_SATURATE_EN`, 0xFFFF_FFFE without.
- Extra input: 12 valid pulses with N=10 -> only the first 10 stored; sum excludes samples 11-12.
- Async reset mid-STREAM after index 3 accepted -> all outputs 0 immediately; a new 10-sample frame then completes normally with the correct sum.

Source files
------------

// File: rtl/exp_sum_buffer.sv
// -----------------------------------------------------------------------------
// exp_sum_buffer
//
// Softmax stage that sits after the exponent block. One frame of exponent
// results is captured into a local buffer while their sum is accumulated.
// Each stored exponent is then replayed to the divider together with the
// final frame sum over a valid/ready handshake. The block handles a single
// frame: after the last pair is accepted it holds sum_done_o until reset.
//
// Optional feature macro: EXP_SUM_SATURATE_EN
//   defined     -> div_sum_o saturates to all ones when the sum overflows
//   not defined -> div_sum_o is the low data_size bits of the sum (wrap)
//
// Ports:
//   clock_i      in   1          rising-edge clock
//   reset_n_i    in   1          asynchronous active-low reset
//   exp_i        in   data_size  exponent value
//   exp_valid_i  in   1          exp_i valid this cycle
//   exp_done_i   in   1          exponent block finished the frame (level)
//   div_ready_i  in   1          divider accepts current pair
//   div_valid_o  out  1          div_exp_o/div_sum_o/div_index_o valid
//   div_exp_o    out  data_size  stored exponent being replayed
//   div_sum_o    out  data_size  frame sum
//   div_index_o  out  8          buffer index of div_exp_o
//   sum_valid_o  out  1          frame sum final (sticky)
//   sum_done_o   out  1          all entries accepted (sticky)
// -----------------------------------------------------------------------------
module exp_sum_buffer #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [data_size-1:0] exp_i,
    input  logic                 exp_valid_i,
    input  logic                 exp_done_i,
    input  logic                 div_ready_i,
    output logic                 div_valid_o,
    output logic [data_size-1:0] div_exp_o,
    output logic [data_size-1:0] div_sum_o,
    output logic [7:0]           div_index_o,
    output logic                 sum_valid_o,
    output logic                 sum_done_o
);

    localparam int          AW      = (number_of_data > 1) ? $clog2(number_of_data) : 1;
    localparam logic [7:0]  N_C     = 8'(number_of_data);
    localparam int          ACC_W   = data_size + 8;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SUM     = 2'd1,
        ST_STREAM  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [7:0]             wr_cnt_q;
    logic [7:0]             rd_cnt_q;
    logic [ACC_W-1:0]       acc_q;
    logic [data_size-1:0]   buffer_q [number_of_data];

    logic                   capture_s;
    logic                   last_accept_s;
    logic [7:0]             rd_next_s;
    logic [data_size-1:0]   sum_s;

    // A sample is taken only while collecting and only while the buffer has room.
    assign capture_s     = (state_q == ST_COLLECT) && exp_valid_i && (wr_cnt_q < N_C);
    assign last_accept_s = (rd_cnt_q == (wr_cnt_q - 8'd1));
    assign rd_next_s     = rd_cnt_q + 8'd1;

`ifdef EXP_SUM_SATURATE_EN
    // Any bit above data_size means the frame sum no longer fits.
    assign sum_s = (|acc_q[ACC_W-1:data_size]) ? {data_size{1'b1}} : acc_q[data_size-1:0];
`else
    // Wrapping build keeps the full-width accumulator; upper bits go unused.
    logic unused_acc_hi_s;
    assign unused_acc_hi_s = ^acc_q[ACC_W-1:data_size];
    assign sum_s           = acc_q[data_size-1:0];
`endif

    // Sample storage; contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clock_i) begin
        if (capture_s) begin
            buffer_q[wr_cnt_q[AW-1:0]] <= exp_i;
        end
    end

    // Control FSM, counters, accumulator and all registered outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_COLLECT;
            wr_cnt_q    <= 8'd0;
            rd_cnt_q    <= 8'd0;
            acc_q       <= {ACC_W{1'b0}};
            div_valid_o <= 1'b0;
            div_exp_o   <= {data_size{1'b0}};
            div_sum_o   <= {data_size{1'b0}};
            div_index_o <= 8'd0;
            sum_valid_o <= 1'b0;
            sum_done_o  <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (capture_s) begin
                        wr_cnt_q <= wr_cnt_q + 8'd1;
                        acc_q    <= acc_q + {8'd0, exp_i};
                    end
                    // Decided on the registered count, so a sample arriving
                    // with exp_done_i is always counted before the frame closes.
                    if ((wr_cnt_q == N_C) || (exp_done_i && (wr_cnt_q != 8'd0))) begin
                        state_q <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    div_sum_o   <= sum_s;
                    sum_valid_o <= 1'b1;
                    div_valid_o <= 1'b1;
                    div_exp_o   <= buffer_q[0];
                    div_index_o <= 8'd0;
                    rd_cnt_q    <= 8'd0;
                    state_q     <= ST_STREAM;
                end
                ST_STREAM: begin
                    // Outputs only move on acceptance, so they hold while stalled.
                    if (div_ready_i) begin
                        if (last_accept_s) begin
                            div_valid_o <= 1'b0;
                            sum_done_o  <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            rd_cnt_q    <= rd_next_s;
                            div_exp_o   <= buffer_q[rd_next_s[AW-1:0]];
                            div_index_o <= rd_next_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_sum_buffer.sv
module tb_exp_sum_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] exp_i;
    logic        exp_valid;
    logic        exp_done;
    logic        div_ready;
    logic        div_valid;
    logic [31:0] div_exp;
    logic [31:0] div_sum;
    logic [7:0]  div_index;
    logic        sum_valid;
    logic        sum_done;

    int checks = 0;
    int errors = 0;

    exp_sum_buffer #(.data_size(32), .number_of_data(10)) dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .exp_i       (exp_i),
        .exp_valid_i (exp_valid),
        .exp_done_i  (exp_done),
        .div_ready_i (div_ready),
        .div_valid_o (div_valid),
        .div_exp_o   (div_exp),
        .div_sum_o   (div_sum),
        .div_index_o (div_index),
        .sum_valid_o (sum_valid),
        .sum_done_o  (sum_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        exp_i     = 32'd0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        div_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic send(input logic [31:0] v);
        exp_i     = v;
        exp_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({div_valid, div_exp, div_sum, div_index, sum_valid, sum_done} !== 75'd0) begin
            errors++;
            $display("FAIL reset_values got v=%0b e=%h s=%h i=%0d sv=%0b sd=%0b want all 0",
                     div_valid, div_exp, div_sum, div_index, sum_valid, sum_done);
        end
    endtask

    // Stream n entries with ready high; entry i must carry exp0 + i*step.
    task automatic drain_ready(input string name, input int n, input logic [31:0] exp0,
                               input logic [31:0] step);
        div_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (div_valid !== 1'b1 || div_index !== 8'(i) || div_exp !== exp0 + step * 32'(i)
                || sum_done !== 1'b0) begin
                errors++;
                $display("FAIL %s_entry%0d got v=%0b i=%0d e=%h sd=%0b want v=1 i=%0d e=%h sd=0",
                         name, i, div_valid, div_index, div_exp, sum_done, i, exp0 + step * 32'(i));
            end
            tick();
        end
        checks++;
        if (sum_done !== 1'b1 || div_valid !== 1'b0 || sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got sd=%0b v=%0b sv=%0b want sd=1 v=0 sv=1",
                     name, sum_done, div_valid, sum_valid);
        end
    endtask

    task automatic test_full_frame();
        apply_reset();
        div_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h0001_0000);
        tick();
        checks++;
        if (sum_valid !== 1'b0 || div_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_k1 got sv=%0b v=%0b want 0 0", sum_valid, div_valid);
        end
        tick();
        checks++;
        if (sum_valid !== 1'b1 || div_sum !== 32'h000A_0000) begin
            errors++;
            $display("FAIL full_sum got sv=%0b s=%h want sv=1 s=000a0000", sum_valid, div_sum);
        end
        drain_ready("full", 10, 32'h0001_0000, 32'd0);
    endtask

    task automatic test_backpressure();
        logic pat [4];
        int   idx;
        logic acc;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        apply_reset();
        for (int i = 0; i < 10; i++) send(32'(i + 1));
        tick();
        tick();
        idx = 0;
        for (int c = 0; c < 80 && sum_done !== 1'b1; c++) begin
            div_ready = pat[c % 4];
            if (div_valid === 1'b1) begin
                checks++;
                if (div_exp !== 32'(idx + 1) || div_index !== 8'(idx)) begin
                    errors++;
                    $display("FAIL bp_cycle%0d got e=%0d i=%0d want e=%0d i=%0d",
                             c, div_exp, div_index, idx + 1, idx);
                end
            end
            acc = div_valid & div_ready;
            tick();
            if (acc) idx++;
        end
        checks++;
        if (idx != 10 || sum_done !== 1'b1 || div_sum !== 32'd55) begin
            errors++;
            $display("FAIL bp_total got accepted=%0d sd=%0b s=%0d want 10 1 55",
                     idx, sum_done, div_sum);
        end
    endtask

    task automatic test_short_frame();
        apply_reset();
        for (int i = 0; i < 4; i++) send(32'(5 + i));
        exp_done = 1'b1;
        tick();
        tick();
        checks++;
        if (div_sum !== 32'd26 || sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL short_sum got s=%0d sv=%0b want 26 1", div_sum, sum_valid);
        end
        drain_ready("short", 4, 32'd5, 32'd1);
    endtask

    task automatic test_overflow();
        logic [31:0] want;
`ifdef EXP_SUM_SATURATE_EN
        want = 32'hFFFF_FFFF;
`else
        want = 32'hFFFF_FFFE;
`endif
        apply_reset();
        send(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        exp_done = 1'b1;
        tick();
        tick();
        checks++;
        if (div_sum !== want) begin
            errors++;
            $display("FAIL overflow_sum got %h want %h", div_sum, want);
        end
    endtask

    task automatic test_extra_input();
        apply_reset();
        exp_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_i = 32'(i + 1);
            tick();
        end
        exp_valid = 1'b0;
        checks++;
        if (div_sum !== 32'd55 || div_valid !== 1'b1) begin
            errors++;
            $display("FAIL extra_sum got s=%0d v=%0b want 55 1", div_sum, div_valid);
        end
        drain_ready("extra", 10, 32'd1, 32'd1);
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        for (int i = 0; i < 10; i++) send(32'(100 + i));
        tick();
        tick();
        div_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (div_index !== 8'd4) begin
            errors++;
            $display("FAIL midrst_pre got i=%0d want 4", div_index);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({div_valid, div_exp, div_sum, div_index, sum_valid, sum_done} !== 75'd0) begin
            errors++;
            $display("FAIL midrst_async got v=%0b e=%h s=%h i=%0d sv=%0b sd=%0b want all 0",
                     div_valid, div_exp, div_sum, div_index, sum_valid, sum_done);
        end
        tick();
        rst_n     = 1'b1;
        div_ready = 1'b0;
        #2;
        for (int i = 0; i < 10; i++) send(32'd2 * 32'(i + 1));
        tick();
        tick();
        checks++;
        if (div_sum !== 32'd110) begin
            errors++;
            $display("FAIL midrst_sum got %0d want 110", div_sum);
        end
        drain_ready("midrst", 10, 32'd2, 32'd2);
    endtask

    initial begin
        rst_n     = 1'b0;
        exp_i     = 32'd0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        div_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_overflow();
        test_extra_input();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
